// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the hazard controller's pipeline-facing signals.
//   Inputs to the controller: ID register fields, EX load/branch/mdu status,
//   ID jump decode and the data-memory stall.
//   Outputs from the controller: stage-register write enables, flushes,
//   MDU status and the stall cycle counter.
//   master: the pipeline side (drives status, receives controls).
//   slave : the hazard controller.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        id_jump;
    logic        ex_mdu_start;
    logic        mem_stall;

    logic        pc_wr;
    logic        if_id_wr;
    logic        id_ex_wr;
    logic        ex_mem_wr;
    logic        mem_wb_wr;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        mdu_busy;
    logic        mdu_done;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, id_jump, ex_mdu_start, mem_stall,
        input  pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mdu_busy, mdu_done, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, id_jump, ex_mdu_start, mem_stall,
        output pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mdu_busy, mdu_done, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Five-stage pipeline hazard controller. Resolves, in priority order,
//   data-memory stall, multi-cycle mul/div stall, taken-branch flush,
//   load-use stall and jump flush into stage-register write enables and
//   NOP-insert flushes. Counts cycles in which the PC is held.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   hz    : pipe_hazard_ctrl_if.slave (status in, controls out)
// Parameter
//   MDU_LAT : stall cycles per mul/div operation (2..65535)
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_LAT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [0:0]  S_RUN  = 1'b0;
    localparam logic [0:0]  S_MDU  = 1'b1;
    localparam logic [15:0] LAT_M1 = 16'(MDU_LAT - 1);

    logic [0:0]  state;
    logic [15:0] cnt;
    logic        skip;
    logic [15:0] stall_cnt_q;

    logic        load_use;
    logic        mdu_start;
    logic        mdu_stall;
    logic        pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        mdu_done;

    // r0 is never a real producer, so a load to r0 cannot cause a hazard.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.ex_rd == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

    // skip masks the mul/div that just finished and is still sitting in EX
    // for one more cycle, so it is not started a second time.
    assign mdu_start = (state == S_RUN) && hz.ex_mdu_start && !skip && !hz.mem_stall;
    assign mdu_stall = (state == S_MDU) || mdu_start;

    always_comb begin
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        id_ex_wr     = 1'b1;
        ex_mem_wr    = 1'b1;
        mem_wb_wr    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        mdu_done     = 1'b0;
        if (!rst_n) begin
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_wr  = 1'b0;
            ex_mem_wr = 1'b0;
            mem_wb_wr = 1'b0;
        end else if (hz.mem_stall) begin
            // Freeze front of pipe; retire a bubble into WB so the stalled
            // MEM instruction is not written back twice.
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            id_ex_wr     = 1'b0;
            ex_mem_wr    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (mdu_stall) begin
            // Hold the mul/div in EX, feed bubbles into MEM.
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            id_ex_wr     = 1'b0;
            ex_mem_flush = 1'b1;
            mdu_done     = (state == S_MDU) && (cnt == 16'd1);
        end else if (hz.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (hz.id_jump) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            cnt   <= 16'd0;
            skip  <= 1'b0;
        end else if (!hz.mem_stall) begin
            if (state == S_RUN) begin
                skip <= 1'b0;
                if (mdu_start) begin
                    state <= S_MDU;
                    cnt   <= LAT_M1;
                end
            end else begin
                if (cnt == 16'd1) begin
                    state <= S_RUN;
                    skip  <= 1'b1;
                    cnt   <= 16'd0;
                end else begin
                    cnt <= cnt - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= 16'd0;
        else if (!pc_wr && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign hz.pc_wr        = pc_wr;
    assign hz.if_id_wr     = if_id_wr;
    assign hz.id_ex_wr     = id_ex_wr;
    assign hz.ex_mem_wr    = ex_mem_wr;
    assign hz.mem_wb_wr    = mem_wb_wr;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.mem_wb_flush = mem_wb_flush;
    assign hz.mdu_busy     = rst_n && (state == S_MDU);
    assign hz.mdu_done     = mdu_done;
    assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (MDU_LAT=4). Directed vectors push their
// hand-computed output vector into a queue; a monitor pops one entry per
// falling edge and compares it with the DUT.
// Vector bit order: {pc,if_id,id_ex,ex_mem,mem_wb wr | if_id,id_ex,ex_mem,mem_wb flush | busy, done}
module tb_pipe_hazard_ctrl;

    localparam logic [10:0] V_ZERO = 11'b00000_0000_00;
    localparam logic [10:0] V_NORM = 11'b11111_0000_00;
    localparam logic [10:0] V_LU   = 11'b00111_0100_00;
    localparam logic [10:0] V_BR   = 11'b11111_1100_00;
    localparam logic [10:0] V_JMP  = 11'b11111_1000_00;
    localparam logic [10:0] V_MS   = 11'b00001_0001_00;  // mem_stall in RUN
    localparam logic [10:0] V_MSB  = 11'b00001_0001_10;  // mem_stall in MDU
    localparam logic [10:0] V_MST  = 11'b00011_0010_00;  // mdu start cycle
    localparam logic [10:0] V_MDU  = 11'b00011_0010_10;  // mdu state
    localparam logic [10:0] V_MDN  = 11'b00011_0010_11;  // mdu last cycle

    typedef struct {
        logic [10:0] vec;
        logic [15:0] sc;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(.MDU_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] tb_sc  = 16'd0;

    // Monitor: outputs are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [10:0] act;
            e   = q.pop_front();
            act = {hz_if.pc_wr, hz_if.if_id_wr, hz_if.id_ex_wr, hz_if.ex_mem_wr,
                   hz_if.mem_wb_wr, hz_if.if_id_flush, hz_if.id_ex_flush,
                   hz_if.ex_mem_flush, hz_if.mem_wb_flush, hz_if.mdu_busy,
                   hz_if.mdu_done};
            n_cmp++;
            if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b want %b", e.name, act, e.vec);
            end
            n_cmp++;
            if (hz_if.stall_cnt !== e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, hz_if.stall_cnt, e.sc);
            end
        end
    end

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic urt, input logic mr, input logic br,
                          input logic jmp, input logic mdu, input logic ms);
        hz_if.id_rs           = rs;
        hz_if.id_rt           = rt;
        hz_if.ex_rd           = rd;
        hz_if.id_uses_rt      = urt;
        hz_if.ex_mem_read     = mr;
        hz_if.ex_branch_taken = br;
        hz_if.id_jump         = jmp;
        hz_if.ex_mdu_start    = mdu;
        hz_if.mem_stall       = ms;
    endtask

    task automatic push(input string nm, input logic [10:0] v);
        exp_t e;
        e.vec  = v;
        e.sc   = tb_sc;
        e.name = nm;
        q.push_back(e);
        // Counter observed this cycle is pre-edge; it steps at the next edge.
        if (!v[10] && rst_n && tb_sc != 16'hFFFF) tb_sc = tb_sc + 16'd1;
    endtask

    task automatic step(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urt, input logic mr,
                        input logic br, input logic jmp, input logic mdu,
                        input logic ms, input logic [10:0] v);
        @(posedge clk);
        #1;
        set_in(rs, rt, rd, urt, mr, br, jmp, mdu, ms);
        push(nm, v);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        push("reset", V_ZERO);
        @(negedge clk);
        #2 rst_n = 1'b1;

        //        name          rs  rt  rd urt mr br jp md ms  expected
        step("idle",           1,  2,  3, 1, 0, 0, 0, 0, 0, V_NORM);
        step("lu_rs",          5,  0,  5, 0, 1, 0, 0, 0, 0, V_LU);
        step("lu_after",       5,  0,  5, 0, 0, 0, 0, 0, 0, V_NORM);
        step("rd_zero",        0,  0,  0, 1, 1, 0, 0, 0, 0, V_NORM);
        step("lu_rt",          1,  7,  7, 1, 1, 0, 0, 0, 0, V_LU);
        step("rt_unused",      1,  7,  7, 0, 1, 0, 0, 0, 0, V_NORM);
        step("no_load",        5,  0,  5, 0, 0, 0, 0, 0, 0, V_NORM);
        step("br_over_lu",     5,  0,  5, 0, 1, 1, 0, 0, 0, V_BR);
        step("jump",           1,  2,  3, 0, 0, 0, 1, 0, 0, V_JMP);
        step("lu_over_jump",   9,  0,  9, 0, 1, 0, 1, 0, 0, V_LU);
        step("mem_stall",      1,  2,  3, 0, 0, 0, 0, 0, 1, V_MS);
        step("ms_over_br",     1,  2,  3, 0, 0, 1, 0, 0, 1, V_MS);

        // mul/div held in EX for its whole stall plus the following cycle
        step("mdu_start",      1,  2,  3, 0, 0, 1, 0, 1, 0, V_MST);
        step("mdu_c3",         1,  2,  3, 0, 0, 0, 0, 1, 0, V_MDU);
        step("mdu_c2",         1,  2,  3, 0, 0, 0, 0, 1, 0, V_MDU);
        step("mdu_done",       1,  2,  3, 0, 0, 0, 0, 1, 0, V_MDN);
        step("mdu_no_restart", 1,  2,  3, 0, 0, 0, 0, 1, 0, V_NORM);
        step("mdu_after",      1,  2,  3, 0, 0, 0, 0, 0, 0, V_NORM);

        // mem_stall freezes the count for two cycles mid-operation
        step("mdms_start",     1,  2,  3, 0, 0, 0, 0, 1, 0, V_MST);
        step("mdms_c3",        1,  2,  3, 0, 0, 0, 0, 1, 0, V_MDU);
        step("mdms_ms1",       1,  2,  3, 0, 0, 0, 0, 1, 1, V_MSB);
        step("mdms_ms2",       1,  2,  3, 0, 0, 0, 0, 1, 1, V_MSB);
        step("mdms_c2",        1,  2,  3, 0, 0, 0, 0, 1, 0, V_MDU);
        step("mdms_done",      1,  2,  3, 0, 0, 0, 0, 1, 0, V_MDN);
        step("mdms_after",     1,  2,  3, 0, 0, 0, 0, 0, 0, V_NORM);

        // reset asserted while cnt==2 aborts the operation
        step("mdrs_start",     1,  2,  3, 0, 0, 0, 0, 1, 0, V_MST);
        step("mdrs_c3",        1,  2,  3, 0, 0, 0, 0, 1, 0, V_MDU);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_in(1, 2, 3, 0, 0, 0, 0, 0, 0);
        tb_sc = 16'd0;
        push("rst_mid_mdu", V_ZERO);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step("post_rst",       1,  2,  3, 0, 0, 0, 0, 0, 0, V_NORM);
        step("post_rst_lu",    4,  0,  4, 0, 1, 0, 0, 0, 0, V_LU);
        step("post_rst_idle",  1,  2,  3, 0, 0, 0, 0, 0, 0, V_NORM);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32, total stall cycles per multiply/divide operation; legal range 2..65535.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, the block's only clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have inputs: id_rs  in  5  ID rs field; id_rt  in  5  ID rt field; id_uses_rt  in  1  ID instruction reads rt; ex_mem_read  in  1  EX instruction is a load; ex_rd  in  5  EX destination register.
REQ-004 SHALL have inputs: ex_branch_taken  in  1  branch resolved taken in EX; id_jump  in  1  jump decoded in ID; ex_mdu_start  in  1  EX holds a mul/div; mem_stall  in  1  data memory not ready.
REQ-005 SHALL have outputs: pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr  out  1 each  stage-register write enables.
REQ-006 SHALL have outputs: if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load NOP into that register on its write.
REQ-007 SHALL have outputs: mdu_busy  out  1  FSM in MDU; mdu_done  out  1  last MDU stall cycle; stall_cnt  out  16  cycles with pc_wr=0.

Function
REQ-008 SHALL implement FSM states RUN and MDU, plus 16-bit down-counter cnt and 1-bit flag skip.
REQ-009 Outputs SHALL be combinational from state, cnt, skip and inputs; registers SHALL update on rising clk.
REQ-010 Priority, highest first: mem_stall, MDU stall, branch flush, load-use, jump flush.
REQ-011 mem_stall=1: pc_wr, if_id_wr, id_ex_wr, ex_mem_wr=0; mem_wb_wr=1, mem_wb_flush=1; other flushes 0; cnt, state and skip frozen.
REQ-012 MDU start: in RUN with ex_mdu_start=1, skip=0, mem_stall=0 -> stall this cycle; next state MDU, cnt<=MDU_LAT-1.
REQ-013 MDU stall cycle (start cycle or state MDU): pc_wr, if_id_wr, id_ex_wr=0; ex_mem_wr=1, ex_mem_flush=1; mem_wb_wr=1.
REQ-014 In MDU without mem_stall: cnt decrements each cycle; at cnt==1 mdu_done=1 and next state RUN, skip<=1.
REQ-015 skip SHALL clear on the first RUN cycle without mem_stall; while skip=1, ex_mdu_start SHALL be ignored, so a held instruction is not restarted.
REQ-016 Branch: ex_branch_taken=1 with no higher-priority stall -> all wr=1, if_id_flush=1, id_ex_flush=1; branch overrides load-use.
REQ-017 Load-use: ex_mem_read=1, ex_rd!=0, and ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt) -> pc_wr=0, if_id_wr=0, id_ex_wr=1, id_ex_flush=1; lasts one cycle.
REQ-018 Jump: id_jump=1 with no higher-priority condition -> all wr=1, if_id_flush=1.
REQ-019 No condition active: all wr=1, all flush=0.
REQ-020 mdu_busy SHALL equal (state==MDU).
REQ-021 stall_cnt SHALL increment on every clock edge where pc_wr=0 and SHALL saturate at 0xFFFF.

Reset
REQ-022 rst_n=0 SHALL immediately force state=RUN, cnt=0, skip=0 and stall_cnt=0.
REQ-023 While rst_n=0, all wr, flush, mdu_busy and mdu_done outputs SHALL be 0.
REQ-024 Reset asserted mid-MDU SHALL abort the operation; after release the FSM is in RUN with no residual stall.

Verification
REQ-025 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle -> pc_wr=0, if_id_wr=0, id_ex_flush=1 for exactly 1 cycle; stall_cnt=1.
REQ-026 ex_rd=0 with id_rs=0 and ex_mem_read=1 -> no stall; all wr=1.
REQ-027 MDU_LAT=4, ex_mdu_start held 6 cycles -> pc_wr=0 for exactly 4 cycles; mdu_done on the 4th; no restart; stall_cnt=4.
REQ-028 ex_branch_taken=1 together with a load-use match -> pc_wr=1, if_id_flush=1, id_ex_flush=1.
REQ-029 mem_stall pulsed 2 cycles mid-MDU (MDU_LAT=4) -> 6 total pc_wr=0 cycles; mem_wb_flush=1 during the mem_stall cycles.
REQ-030 rst_n pulled low at cnt==2 in MDU -> outputs 0 at once; after release all wr=1 and mdu_busy=0.
